// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam int DEPTH_DEF      = 1024;
  localparam int LEN_W_DEF      = 11;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  function automatic logic len_legal(input logic [31:0] len, input int depth);
    return (len != 32'd0) && (len <= 32'(depth));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction memory write port out.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; shared by program words and trailer.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_fire,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        word_ready
);

  logic [BCNT_W-1:0] byte_cnt;

  // word_next already holds the byte being accepted so the trailer can be compared in-cycle
  always_comb begin
    word_next = word;
    if (byte_fire) word_next[{byte_cnt, 3'b000} +: 8] = byte_data;
  end

  assign word_ready = byte_fire && (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
    end else if (byte_fire) begin
      byte_cnt <= byte_cnt + BCNT_W'(1);
      word     <= word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams words into instruction memory, verifies an additive checksum,
// then releases the core from reset.
//
//   state | meaning
//   IDLE  | waiting for load_start after reset
//   RECV  | collecting 4 bytes of a program word
//   WRITE | one-cycle memory write, checksum accumulate
//   CHECK | collecting the 4-byte checksum trailer
//   DONE  | load verified, core released
//   ERR   | bad length or checksum mismatch, core held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [LEN_W-1:0]   load_len,
  imem_loader_if.master      bus,
  output logic               cpu_rst,
  output logic               done,
  output logic               error
);

  state_t            state, next_state;
  logic [LEN_W-1:0]  len_q, word_idx;
  logic [31:0]       checksum, word, word_next;
  logic              word_ready, byte_fire, arm, len_ok, last_word;
  logic              in_ready_q, mem_we_q, done_q, error_q, cpu_rst_q;
  logic              in_ready_d, mem_we_d, done_d, error_d, cpu_rst_d;

  assign arm       = load_start &&
                     (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign len_ok    = len_legal(32'(load_len), DEPTH);
  assign byte_fire = bus.in_valid && in_ready_q;
  assign last_word = (word_idx == len_q - LEN_W'(1));

  imem_loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (arm),
    .byte_fire  (byte_fire),
    .byte_data  (bus.in_data),
    .word       (word),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  // Outputs are decoded from next_state and registered alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_rst_q  <= 1'b0;
    end else begin
      state      <= next_state;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR:
        if (load_start) next_state = len_ok ? ST_RECV : ST_ERR;
      ST_RECV:
        if (word_ready) next_state = ST_WRITE;
      ST_WRITE:
        next_state = last_word ? ST_CHECK : ST_RECV;
      ST_CHECK:
        if (word_ready) next_state = (word_next == checksum) ? ST_DONE : ST_ERR;
      default:
        next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_d = (next_state == ST_RECV) || (next_state == ST_CHECK);
    mem_we_d   = (next_state == ST_WRITE);
    done_d     = (next_state == ST_DONE);
    error_d    = (next_state == ST_ERR);
    cpu_rst_d  = (next_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q    <= '0;
      word_idx <= '0;
      checksum <= '0;
    end else if (arm && len_ok) begin
      len_q    <= load_len;
      word_idx <= '0;
      checksum <= '0;
    end else if (state == ST_WRITE) begin
      checksum <= checksum + word;
      word_idx <= word_idx + LEN_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = 32'({word_idx, 2'b00});
  assign bus.mem_wdata = word;
  assign done          = done_q;
  assign error         = error_q;
  assign cpu_rst       = cpu_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, mismatch, wrap, gaps, bad length, reset, full depth.
module tb_imem_loader;

  localparam int DEPTH = 1024;
  localparam int LEN_W = 11;

  logic             clk;
  logic             rst;
  logic             load_start;
  logic [LEN_W-1:0] load_len;
  logic             cpu_rst, done, error;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .bus        (bus),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // write log, filled on the falling edge while the loader is out of reset
  logic [31:0] wr_addr [4096];
  logic [31:0] wr_data [4096];
  int          wr_cnt   = 0;
  int          rdy_viol = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.mem_we === 1'b1) begin
      if (wr_cnt < 4096) begin
        wr_addr[wr_cnt] <= bus.mem_addr;
        wr_data[wr_cnt] <= bus.mem_wdata;
      end
      last_addr <= bus.mem_addr;
      last_data <= bus.mem_wdata;
      wr_cnt    <= wr_cnt + 1;
      if (bus.in_ready !== 1'b0) rdy_viol <= rdy_viol + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [LEN_W-1:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
    load_len   = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    int budget;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) check("byte_timeout", 32'(budget), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
  endtask

  task automatic send_nominal(input logic [31:0] trailer, input int max_gap);
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    for (int i = 0; i < 8; i++) send_byte(prog[i], max_gap);
    send_word(trailer, max_gap);
  endtask

  task automatic check_nominal_writes(input string tag, input int base);
    check({tag, "_wr_cnt"}, 32'(wr_cnt - base), 32'd2);
    check({tag, "_addr0"},  wr_addr[base],     32'h0000_0000);
    check({tag, "_data0"},  wr_data[base],     32'h0050_0513);
    check({tag, "_addr1"},  wr_addr[base + 1], 32'h0000_0004);
    check({tag, "_data1"},  wr_data[base + 1], 32'h00A0_0593);
  endtask

  int base;
  int viol_base;

  initial begin
    rst          = 1'b0;
    load_start   = 1'b0;
    load_len     = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    #3;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we",   32'(bus.mem_we),   32'd0);
    check("rst_done",     32'(done),         32'd0);
    check("rst_error",    32'(error),        32'd0);
    check("rst_cpu_rst",  32'(cpu_rst),      32'd0);
    check("rst_addr",     bus.mem_addr,      32'd0);
    check("rst_wdata",    bus.mem_wdata,     32'd0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // nominal load
    base = wr_cnt; viol_base = rdy_viol;
    start_load(11'd2);
    check("recv_in_ready", 32'(bus.in_ready), 32'd1);
    send_nominal(32'h00F0_0AA6, 0);
    check_nominal_writes("nom", base);
    check("nom_done",    32'(done),    32'd1);
    check("nom_cpu_rst", 32'(cpu_rst), 32'd1);
    check("nom_error",   32'(error),   32'd0);
    check("nom_rdy_in_write", 32'(rdy_viol - viol_base), 32'd0);

    // re-arm from DONE, then checksum mismatch
    base = wr_cnt;
    start_load(11'd2);
    check("rearm_cpu_rst", 32'(cpu_rst), 32'd0);
    check("rearm_done",    32'(done),    32'd0);
    send_nominal(32'h00F0_0AA7, 0);
    check_nominal_writes("mis", base);
    check("mis_error",   32'(error),   32'd1);
    check("mis_cpu_rst", 32'(cpu_rst), 32'd0);
    check("mis_done",    32'(done),    32'd0);

    // checksum wraps modulo 2^32
    base = wr_cnt;
    start_load(11'd2);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0001, 0);
    check("wrap_data0", wr_data[base],     32'hFFFF_FFFF);
    check("wrap_data1", wr_data[base + 1], 32'h0000_0002);
    check("wrap_done",  32'(done),         32'd1);
    check("wrap_error", 32'(error),        32'd0);

    // random gaps on in_valid
    base = wr_cnt; viol_base = rdy_viol;
    start_load(11'd2);
    send_nominal(32'h00F0_0AA6, 3);
    check_nominal_writes("gap", base);
    check("gap_done", 32'(done), 32'd1);
    check("gap_rdy_in_write", 32'(rdy_viol - viol_base), 32'd0);

    // illegal lengths
    base = wr_cnt;
    start_load(11'd0);
    check("len0_error",    32'(error),        32'd1);
    check("len0_done",     32'(done),         32'd0);
    check("len0_cpu_rst",  32'(cpu_rst),      32'd0);
    check("len0_in_ready", 32'(bus.in_ready), 32'd0);
    start_load(11'(DEPTH + 1));
    repeat (3) @(negedge clk);
    check("lenbig_error",    32'(error),        32'd1);
    check("lenbig_in_ready", 32'(bus.in_ready), 32'd0);
    check("badlen_no_write", 32'(wr_cnt - base), 32'd0);

    // asynchronous reset after 5 bytes
    start_load(11'd2);
    for (int i = 0; i < 5; i++) send_byte(8'h11 * 8'(i + 1), 0);
    check("pre_rst_addr", bus.mem_addr, 32'h0000_0004);
    #2 rst = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check("arst_mem_we",   32'(bus.mem_we),   32'd0);
    check("arst_done",     32'(done),         32'd0);
    check("arst_error",    32'(error),        32'd0);
    check("arst_cpu_rst",  32'(cpu_rst),      32'd0);
    check("arst_addr",     bus.mem_addr,      32'd0);
    check("arst_wdata",    bus.mem_wdata,     32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'({bus.in_ready, done, error}), 32'd0);
    base = wr_cnt;
    start_load(11'd2);
    send_nominal(32'h00F0_0AA6, 0);
    check_nominal_writes("rst2", base);
    check("rst2_done", 32'(done), 32'd1);

    // full-depth load; word i holds i, a load_start mid-load must be ignored
    base = wr_cnt;
    start_load(11'(DEPTH));
    send_word(32'd0, 0);
    start_load(11'd0);
    for (int i = 1; i < DEPTH; i++) send_word(32'(i), 0);
    check("depth_mid_error", 32'(error), 32'd0);
    send_word(32'h0007_FE00, 0);
    check("depth_wr_cnt",    32'(wr_cnt - base), 32'd1024);
    check("depth_last_addr", last_addr, 32'h0000_0FFC);
    check("depth_last_data", last_data, 32'h0000_03FF);
    check("depth_done",      32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the instruction memory and processor core.
- Accepts a byte stream using valid/ready and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through a write port, then verifies a trailing 32-bit additive checksum.
- Holds the processor in reset (cpu_rst low) until a load completes and passes its check.

Parameters:
- DEPTH, 1024, instruction memory capacity in words; legal load_len range is 1..DEPTH.
- LEN_W, 11, width of load_len; must hold the value DEPTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
- load_len  in  LEN_W  number of program words, sampled with load_start.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both 1.
- mem_we  out  1  instruction memory write enable, one cycle per word.
- mem_addr  out  32  byte address, always word-aligned (word_idx*4).
- mem_wdata  out  32  assembled word.
- cpu_rst  out  1  active-low reset to the processor; 0 holds the core in reset.
- done  out  1  load finished and checksum matched.
- error  out  1  bad length or checksum mismatch.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - in_ready, mem_we, done, error and cpu_rst are all 0.
  - mem_addr, mem_wdata, the byte counter, word_idx and the checksum accumulator are all 0.
  - Reset mid-load abandons the load entirely; memory already written is not cleared.
- States: IDLE, RECV, WRITE, CHECK, DONE, ERR.
- IDLE:
  - in_ready=0.
  - On load_start with 1<=load_len<=DEPTH: latch len, clear word_idx and checksum, go to RECV.
  - On load_start with load_len==0 or load_len>DEPTH: go to ERR.
- RECV:
  - in_ready=1.
  - The k-th accepted byte (k=0..3) goes to word[8k+7:8k].
  - On the 4th accepted byte, go to WRITE next cycle.
  - Gaps where in_valid=0 are allowed; no timeout.
- WRITE (exactly 1 cycle):
  - mem_we=1, mem_addr=word_idx*4, mem_wdata=word, in_ready=0.
  - checksum <= checksum + word, modulo 2^32 (carry discarded).
  - word_idx increments.
  - If this was word len-1, go to CHECK; otherwise go to RECV.
- Throughput and latency:
  - Throughput is 5 cycles per word at full rate.
  - The write appears the cycle after the 4th byte handshake.
- CHECK:
  - in_ready=1; assemble 4 trailer bytes little-endian.
  - Trailer equal to checksum: go to DONE. Otherwise go to ERR.
  - No memory write occurs in CHECK.
- DONE:
  - done=1, cpu_rst=1, in_ready=0.
  - load_start re-arms: same length check as IDLE; cpu_rst and done drop to 0 the next cycle.
- ERR:
  - error=1, cpu_rst=0, in_ready=0.
  - load_start re-arms exactly as from IDLE.
- load_start asserted in RECV, WRITE or CHECK is ignored.
- mem_we is never 1 outside WRITE.
- Outputs are registered; no combinational path from in_valid to in_ready.

Decomposition:
- Shared package:
  - State enum constants (IDLE=0, RECV=1, WRITE=2, CHECK=3, DONE=4, ERR=5).
  - DEPTH default.
  - BYTES_PER_WORD=4.
- One natural sub-module, word_assembler:
  - Contains the 2-bit byte counter and the 32-bit shift/insert register, with a word_ready pulse.
  - Instantiated once and reused for both program words and the trailer.

Test Plan:
- Nominal load:
  - Stimulus: load_len=2, bytes 13 05 50 00 93 05 A0 00, then trailer A6 0A F0 00.
  - Required: mem writes (addr 0x0, data 0x00500513) and (addr 0x4, data 0x00A00593); then done=1 and cpu_rst=1.
- Checksum mismatch:
  - Stimulus: same stream with trailer A7 0A F0 00.
  - Required: both writes occur; then error=1, cpu_rst=0, done=0.
- Checksum wrap:
  - Stimulus: load_len=2, words 0xFFFFFFFF and 0x00000002, trailer 01 00 00 00.
  - Required: done=1.
- Backpressure and gaps:
  - Stimulus: in_valid toggled randomly during the nominal load.
  - Required: identical writes; in_ready=0 during each WRITE cycle; no byte lost or duplicated.
- Bad length:
  - Stimulus: load_len=0, then load_len=DEPTH+1.
  - Required: ERR with no mem_we.
  - Stimulus: load_len=DEPTH.
  - Required: last write at addr 0xFFC.
- Reset and re-arm:
  - Stimulus: rst pulsed low after 5 bytes.
  - Required: all outputs 0 immediately (asynchronous), state IDLE; a new nominal load then succeeds.
  - Stimulus: load_start from DONE.
  - Required: cpu_rst=0 on the next cycle.
